// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcode enum, field typedefs and encoding constants.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [5:0]  lc3b_offset6;
  typedef logic [8:0]  lc3b_offset9;
  typedef logic [10:0] lc3b_offset11;
  typedef logic [4:0]  lc3b_imm5;
  typedef logic [3:0]  lc3b_imm4;
  typedef logic [7:0]  lc3b_trapvect8;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  localparam logic [5:0] NOT_IMM6 = 6'h3F;
  localparam lc3b_word   RTI_WORD = 16'h8000;

endpackage

// File: rtl/lc3b_inst_pack.sv
// Combinational encoder: decoded LC-3b fields -> 16-bit instruction word.
module lc3b_inst_pack
  import lc3b_types::*;
(
  input  lc3b_opcode    opcode,
  input  lc3b_reg       dest,
  input  lc3b_reg       src1,
  input  lc3b_reg       src2,
  input  lc3b_offset6   offset6,
  input  lc3b_offset9   offset9,
  input  lc3b_offset11  offset11,
  input  lc3b_imm5      imm5,
  input  lc3b_imm4      imm4,
  input  lc3b_trapvect8 trapvect8,
  input  logic          immOrA_bit,
  input  logic          jsr_bit,
  input  logic          D_bit,
  output lc3b_word      word
);

  always_comb begin
    word = '0;
    unique case (opcode)
      op_br, op_lea: word = {opcode, dest, offset9};
      op_add, op_and: begin
        if (immOrA_bit) word = {opcode, dest, src1, 1'b1, imm5};
        else            word = {opcode, dest, src1, 1'b0, 2'b00, src2};
      end
      op_not: word = {opcode, dest, src1, NOT_IMM6};
      op_ldb, op_stb, op_ldr, op_str, op_ldi, op_sti: word = {opcode, dest, src1, offset6};
      op_jmp: word = {opcode, 3'b000, src1, 6'b000000};
      op_jsr: begin
        if (jsr_bit) word = {opcode, 1'b1, offset11};
        else         word = {opcode, 1'b0, 2'b00, src1, 6'b000000};
      end
      op_shf:  word = {opcode, dest, src1, immOrA_bit, D_bit, imm4};
      op_trap: word = {opcode, 4'b0000, trapvect8};
      op_rti:  word = RTI_WORD;
    endcase
  end

endmodule

// File: rtl/lc3b_inst_encoder.sv
// Encodes LC-3b field sets into words, buffers them and writes them sequentially to memory.
// Optional INST_ENC_CHECK_EN rejects RTI and malformed register-mode ADD/AND with an enc_err pulse.
module lc3b_inst_encoder
  import lc3b_types::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        base_load,
  input  logic [15:0] base_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  opcode,
  input  logic [2:0]  dest,
  input  logic [2:0]  src1,
  input  logic [2:0]  src2,
  input  logic [5:0]  offset6,
  input  logic [8:0]  offset9,
  input  logic [10:0] offset11,
  input  logic [4:0]  imm5,
  input  logic [3:0]  imm4,
  input  logic [7:0]  trapvect8,
  input  logic        immOrA_bit,
  input  logic        jsr_bit,
  input  logic        D_bit,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  input  logic        mem_resp,
  output logic        busy,
  output logic [15:0] words_written,
  output logic        enc_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {StIdle, StWrite} state_e;

  state_e          state_q, state_d;
  lc3b_word        fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  lc3b_word        addr_q, addr_d;
  lc3b_word        wdata_q, wdata_d;
  lc3b_word        words_q, words_d;
  lc3b_word        enc_word;
  logic            accept, push, pop, bad, fifo_empty;

  lc3b_inst_pack u_pack (
    .opcode    (lc3b_opcode'(opcode)),
    .dest      (dest),
    .src1      (src1),
    .src2      (src2),
    .offset6   (offset6),
    .offset9   (offset9),
    .offset11  (offset11),
    .imm5      (imm5),
    .imm4      (imm4),
    .trapvect8 (trapvect8),
    .immOrA_bit(immOrA_bit),
    .jsr_bit   (jsr_bit),
    .D_bit     (D_bit),
    .word      (enc_word)
  );

`ifdef INST_ENC_CHECK_EN
  logic enc_err_q;
  assign bad = (opcode == op_rti) ||
               (((opcode == op_add) || (opcode == op_and)) && !immOrA_bit && (imm5[4:3] != 2'b00));
  always_ff @(posedge clk) begin
    if (rst) enc_err_q <= 1'b0;
    else     enc_err_q <= accept && bad;
  end
  assign enc_err = enc_err_q;
`else
  assign bad     = 1'b0;
  assign enc_err = 1'b0;
`endif

  assign fifo_empty = (count_q == '0);
  assign req_ready  = (count_q != CntW'(FIFO_DEPTH));
  assign accept     = req_valid && req_ready;
  assign push       = accept && !bad;
  assign pop        = (state_q == StWrite) && mem_resp;
  assign busy       = !fifo_empty || (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    words_d = words_q;
    count_d = count_q + CntW'(push) - CntW'(pop);
    unique case (state_q)
      StIdle: begin
        // An accept into an empty buffer starts the write on the same edge.
        if (!fifo_empty || push) begin
          state_d = StWrite;
          wdata_d = fifo_empty ? enc_word : fifo_q[rd_ptr_q];
        end
        if (base_load && !busy) addr_d = {base_addr[15:1], 1'b0};
      end
      StWrite: begin
        if (mem_resp) begin
          state_d = StIdle;
          addr_d  = addr_q + 16'd2;
          words_d = words_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      words_q  <= words_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= enc_word;
  end

  assign mem_write       = (state_q == StWrite);
  assign mem_byte_enable = mem_write ? 2'b11 : 2'b00;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign words_written   = words_q;

endmodule

// File: tb/tb_lc3b_inst_encoder.sv
// Self-checking bench for lc3b_inst_encoder: directed cases plus random requests vs a reference model.
module tb_lc3b_inst_encoder;

  logic        clk = 1'b0;
  logic        rst, base_load, req_valid, req_ready;
  logic [15:0] base_addr;
  logic [3:0]  opcode, imm4;
  logic [2:0]  dest, src1, src2;
  logic [5:0]  offset6;
  logic [8:0]  offset9;
  logic [10:0] offset11;
  logic [4:0]  imm5;
  logic [7:0]  trapvect8;
  logic        immOrA_bit, jsr_bit, D_bit;
  logic [15:0] mem_address, mem_wdata, words_written;
  logic        mem_write, mem_resp, busy, enc_err;
  logic [1:0]  mem_byte_enable;

  lc3b_inst_encoder dut (
    .clk(clk), .rst(rst), .base_load(base_load), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .opcode(opcode), .dest(dest),
    .src1(src1), .src2(src2), .offset6(offset6), .offset9(offset9), .offset11(offset11),
    .imm5(imm5), .imm4(imm4), .trapvect8(trapvect8), .immOrA_bit(immOrA_bit),
    .jsr_bit(jsr_bit), .D_bit(D_bit), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_resp(mem_resp),
    .busy(busy), .words_written(words_written), .enc_err(enc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op; logic [2:0] dest, src1, src2; logic [5:0] off6; logic [8:0] off9;
    logic [10:0] off11; logic [4:0] imm5; logic [3:0] imm4; logic [7:0] trap;
    logic imm_bit, jsr_bit, d_bit;
  } req_t;

  int checks = 0, passed = 0, fails = 0;
  int cyc = 0, resp_cyc = 0, lat = 1, wcnt = 0, low_run = 0, last_gap = 0, unstable = 0;
  bit resp_en = 1'b1, force_resp = 1'b0, was_write = 1'b0;
  logic [15:0] hold_addr, hold_data, mptr = 16'h0, wexp = 16'h0;
  logic [15:0] log_addr[$], log_data[$], exp_addr[$], exp_data[$];

  always @(posedge clk) cyc++;

  // Memory responder: answers each write after lat cycles and logs what was written.
  always @(negedge clk) begin
    mem_resp = force_resp;
    if (mem_write) begin
      if (!was_write) begin
        last_gap = low_run;
        low_run  = 0;
      end else if (mem_address !== hold_addr || mem_wdata !== hold_data) begin
        unstable++;
      end
      hold_addr = mem_address;
      hold_data = mem_wdata;
      if (resp_en) begin
        wcnt++;
        if (wcnt >= lat) begin
          mem_resp = 1'b1;
          wcnt     = 0;
          resp_cyc = cyc;
          log_addr.push_back(mem_address);
          log_data.push_back(mem_wdata);
        end
      end
    end else begin
      low_run++;
      wcnt = 0;
    end
    was_write = mem_write;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding built from field weights rather than bit concatenation.
  function automatic logic [15:0] ref_enc(input req_t r);
    int w, d9, s6;
    w  = int'(r.op) * 4096;
    d9 = int'(r.dest) * 512;
    s6 = int'(r.src1) * 64;
    case (int'(r.op))
      0, 14:             w += d9 + int'(r.off9);
      1, 5:              w += d9 + s6 + (r.imm_bit ? 32 + int'(r.imm5) : int'(r.src2));
      9:                 w += d9 + s6 + 63;
      2, 3, 6, 7, 10, 11: w += d9 + s6 + int'(r.off6);
      12:                w += s6;
      4:                 w += r.jsr_bit ? 2048 + int'(r.off11) : s6;
      13: w += d9 + s6 + 32 * int'(r.imm_bit) + 16 * int'(r.d_bit) + int'(r.imm4);
      15:                w += int'(r.trap);
      default:           w = 32768;
    endcase
    return w[15:0];
  endfunction

  function automatic bit ref_bad(input req_t r);
`ifdef INST_ENC_CHECK_EN
    if (r.op == 4'd8) return 1'b1;
    if ((r.op == 4'd1 || r.op == 4'd5) && !r.imm_bit && r.imm5 >= 5'd8) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic req_t mk(input logic [3:0] op);
    req_t r;
    r = '{op: op, dest: '0, src1: '0, src2: '0, off6: '0, off9: '0, off11: '0,
          imm5: '0, imm4: '0, trap: '0, imm_bit: 1'b0, jsr_bit: 1'b0, d_bit: 1'b0};
    return r;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.op = 4'($urandom); r.dest = 3'($urandom); r.src1 = 3'($urandom);
    r.src2 = 3'($urandom); r.off6 = 6'($urandom); r.off9 = 9'($urandom);
    r.off11 = 11'($urandom); r.imm5 = 5'($urandom); r.imm4 = 4'($urandom);
    r.trap = 8'($urandom); r.imm_bit = 1'($urandom); r.jsr_bit = 1'($urandom);
    r.d_bit = 1'($urandom);
    if (ref_bad(r)) r.op = 4'd15;
    return r;
  endfunction

  // Presents a request from a negedge, waits for acceptance, returns at the following negedge.
  task automatic push(input req_t r, input bit ld, input logic [15:0] ba, output int acc_cyc);
    int n = 0;
    opcode = r.op; dest = r.dest; src1 = r.src1; src2 = r.src2; offset6 = r.off6;
    offset9 = r.off9; offset11 = r.off11; imm5 = r.imm5; imm4 = r.imm4; trapvect8 = r.trap;
    immOrA_bit = r.imm_bit; jsr_bit = r.jsr_bit; D_bit = r.d_bit;
    base_load = ld; base_addr = ba; req_valid = 1'b1;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    base_load = 1'b0;
    if (ld) mptr = ba & 16'hFFFE;
    if (!ref_bad(r)) begin
      exp_addr.push_back(mptr);
      exp_data.push_back(ref_enc(r));
      mptr += 16'd2;
      wexp += 16'd1;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    resp_en = 1'b1;
    while ((busy || mem_write) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_count"}, 32'(log_addr.size()), 32'(exp_addr.size()));
    while (log_addr.size() > 0 && exp_addr.size() > 0) begin
      check({tag, "_addr"}, 32'(log_addr.pop_front()), 32'(exp_addr.pop_front()));
      check({tag, "_data"}, 32'(log_data.pop_front()), 32'(exp_data.pop_front()));
    end
    log_addr.delete(); log_data.delete(); exp_addr.delete(); exp_data.delete();
    check({tag, "_words"}, 32'(words_written), 32'(wexp));
  endtask

  initial begin
    req_t r;
    int   acc;
    rst = 1'b1; base_load = 1'b0; base_addr = '0; req_valid = 1'b0;
    r = mk(4'd0);
    opcode = '0; dest = '0; src1 = '0; src2 = '0; offset6 = '0; offset9 = '0; offset11 = '0;
    imm5 = '0; imm4 = '0; trapvect8 = '0; immOrA_bit = 1'b0; jsr_bit = 1'b0; D_bit = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_byte_enable", 32'(mem_byte_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    check("rst_enc_err", 32'(enc_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ADD immediate at 0x3000; write must start the cycle after accept.
    lat = 3;
    r = mk(4'd1); r.dest = 3'd1; r.src1 = 3'd2; r.imm_bit = 1'b1; r.imm5 = 5'h1F;
    push(r, 1'b1, 16'h3000, acc);
    check("add_write_n1", 32'(mem_write), 32'd1);
    check("add_be", 32'(mem_byte_enable), 32'h3);
    check("add_addr", 32'(mem_address), 32'h3000);
    check("add_data", 32'(mem_wdata), 32'h12BF);
    drain("add");

    // TRAP then NOT back to back, one idle cycle between writes.
    r = mk(4'd15); r.trap = 8'h25;
    push(r, 1'b1, 16'h2000, acc);
    r = mk(4'd9); r.dest = 3'd3; r.src1 = 3'd4;
    push(r, 1'b0, 16'h0, acc);
    drain("trap_not");
    check("gap_one_cycle", 32'(last_gap), 32'd1);

    // JSR both forms.
    lat = 1;
    r = mk(4'd4); r.jsr_bit = 1'b1; r.off11 = 11'h7FF;
    push(r, 1'b0, 16'h0, acc);
    r = mk(4'd4); r.src1 = 3'd5;
    push(r, 1'b0, 16'h0, acc);
    drain("jsr");

    // Address wrap from 0xFFFE to 0x0000, odd base bit dropped.
    r = mk(4'd14); r.dest = 3'd7; r.off9 = 9'h1AB;
    push(r, 1'b1, 16'hFFFF, acc);
    push(r, 1'b0, 16'h0, acc);
    drain("lea_wrap");

    // Backpressure: buffer full after two accepts, third taken the cycle after first resp.
    resp_en = 1'b0; lat = 2;
    r = mk(4'd3); r.dest = 3'd1; r.src1 = 3'd6; r.off6 = 6'h2A;
    push(r, 1'b1, 16'h4000, acc);
    push(r, 1'b0, 16'h0, acc);
    check("full_not_ready", 32'(req_ready), 32'd0);
    resp_en = 1'b1;
    push(r, 1'b0, 16'h0, acc);
    check("third_accept_cycle", 32'(acc), 32'(resp_cyc + 1));
    drain("backpressure");

    // Reset mid-write with a late mem_resp.
    resp_en = 1'b0;
    r = mk(4'd12); r.src1 = 3'd2;
    push(r, 1'b1, 16'h5000, acc);
    check("pre_rst_write", 32'(mem_write), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; force_resp = 1'b1;
    @(negedge clk);
    force_resp = 1'b0;
    exp_addr.delete(); exp_data.delete();
    mptr = 16'h0; wexp = 16'h0;
    check("post_rst_write", 32'(mem_write), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_words", 32'(words_written), 32'd0);
    drain("post_rst");

`ifdef INST_ENC_CHECK_EN
    r = mk(4'd8);
    push(r, 1'b0, 16'h0, acc);
    check("rti_enc_err", 32'(enc_err), 32'd1);
    check("rti_no_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    check("rti_enc_err_pulse", 32'(enc_err), 32'd0);
    drain("rti_drop");
`endif

    // Random requests with random latency and occasional base reloads.
    for (int i = 0; i < 60; i++) begin
      lat = $urandom_range(1, 4);
      r = rnd_req();
      if ($urandom_range(0, 7) == 0) begin
        drain("rand_mid");
        push(r, 1'b1, 16'($urandom), acc);
      end else begin
        push(r, 1'b0, 16'h0, acc);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("rand");
    check("addr_data_stable", 32'(unstable), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
